// File: rtl/svm_pkg.sv
// Shared types and constants for the SVM scheduler traffic generator.
// Mask constants are 32 bits wide and get zero-extended to the dependency width.
package svm_pkg;

  typedef enum logic [1:0] {
    MODE_PERIODIC_WAW = 2'd0,
    MODE_DISJOINT     = 2'd1,
    MODE_LFSR_RANDOM  = 2'd2,
    MODE_ALL_WAW      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] WAW_WRITE_MASK = 32'h0000_00ff;
  localparam logic [31:0] READ_MASK      = 32'h0000_ff00;
  localparam logic [31:0] WRITE_MASK     = 32'hff00_0000;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = 32'h0000_0001;
  localparam logic [31:0] CNT_MAX   = 32'hffff_ffff;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? CNT_MAX : sum[31:0];
  endfunction

endpackage

// File: rtl/svm_lfsr32.sv
// 32-bit Galois LFSR with seed load and single-step control.
// A zero seed would lock the register, so it is replaced by LFSR_INIT.
module svm_lfsr32
  import svm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [15:0] low_bits
);

  logic [31:0] lfsr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_INIT;
    end else if (load) begin
      lfsr_q <= (seed == '0) ? LFSR_INIT : seed;
    end else if (step) begin
      lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    end
  end

  assign low_bits = lfsr_q[15:0];

endmodule

// File: rtl/svm_traffic_gen.sv
// Traffic generator that feeds dependency-tagged transactions into the SVM scheduler
// and sinks its per-channel completions, with run/drain/stall bookkeeping.
module svm_traffic_gen
  import svm_pkg::*;
#(
  parameter int NUM_PARALLEL_INSTANCES = 4,
  parameter int MAX_DEPENDENCIES       = 256,
  parameter int CONFLICT_PERIOD        = 5,
  parameter int STALL_LIMIT            = 500
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [31:0]                       num_txn,
  input  logic [1:0]                        mode,
  input  logic [31:0]                       seed,
  input  logic [NUM_PARALLEL_INSTANCES-1:0] ready_mask,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [63:0]                       m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0]       m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]       m_axis_tdata_write_dependencies,
  input  logic [NUM_PARALLEL_INSTANCES-1:0] s_axis_tvalid,
  output logic [NUM_PARALLEL_INSTANCES-1:0] s_axis_tready,
  output logic                              busy,
  output logic                              done,
  output logic                              stalled,
  output logic [31:0]                       submitted_count,
  output logic [31:0]                       completed_count,
  output logic [31:0]                       cycle_count
);

  localparam int DW = MAX_DEPENDENCIES;
  localparam logic [DW-1:0] ONE = DW'(1);

  state_e      state, state_next;
  mode_e       mode_q;
  logic [31:0] num_txn_q;
  logic [31:0] phase;
  logic [31:0] stall_cnt;
  logic [31:0] completions;
  logic [15:0] lfsr_bits;
  logic        start_ok, beat, last_beat, drained, stall_hit;

  assign start_ok      = start && (state == ST_IDLE || state == ST_DONE);
  assign busy          = (state == ST_SEND) || (state == ST_DRAIN);
  assign done          = (state == ST_DONE);
  assign m_axis_tvalid = (state == ST_SEND);
  assign s_axis_tready = busy ? ready_mask : '0;
  assign beat          = m_axis_tvalid && m_axis_tready;
  assign last_beat     = beat && (sat_add(submitted_count, 32'd1) >= num_txn_q);
  assign drained       = completed_count >= submitted_count;
  assign stall_hit     = (completions == '0) && (stall_cnt == 32'(STALL_LIMIT - 1));

  svm_lfsr32 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .seed     (seed),
    .step     (beat),
    .low_bits (lfsr_bits)
  );

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    completions = '0;
    for (int i = 0; i < NUM_PARALLEL_INSTANCES; i++) begin
      completions = completions + 32'(s_axis_tvalid[i] & s_axis_tready[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_ok) state_next = (num_txn == '0) ? ST_DRAIN : ST_SEND;
      ST_SEND:          if (last_beat) state_next = ST_DRAIN;
      ST_DRAIN:         if (drained || stall_hit) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  // Payload is a pure function of registered index/phase/LFSR, so it holds while tready is low.
  always_comb begin
    m_axis_tdata_owner_programID    = '0;
    m_axis_tdata_read_dependencies  = '0;
    m_axis_tdata_write_dependencies = '0;
    if (state == ST_SEND) begin
      m_axis_tdata_owner_programID = {32'd0, submitted_count};
      case (mode_q)
        MODE_PERIODIC_WAW: begin
          if (phase == '0) begin
            m_axis_tdata_write_dependencies = DW'(WAW_WRITE_MASK);
          end else begin
            m_axis_tdata_read_dependencies  = DW'(READ_MASK);
            m_axis_tdata_write_dependencies = DW'(WRITE_MASK);
          end
        end
        MODE_DISJOINT:
          m_axis_tdata_write_dependencies = ONE << (submitted_count % 32'(DW));
        MODE_LFSR_RANDOM: begin
          m_axis_tdata_read_dependencies  = ONE << ({24'd0, lfsr_bits[15:8]} % 32'(DW));
          m_axis_tdata_write_dependencies = ONE << ({24'd0, lfsr_bits[7:0]} % 32'(DW));
        end
        default:
          m_axis_tdata_write_dependencies = DW'(WAW_WRITE_MASK);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q          <= MODE_PERIODIC_WAW;
      num_txn_q       <= '0;
      phase           <= '0;
      stall_cnt       <= '0;
      stalled         <= 1'b0;
      submitted_count <= '0;
      completed_count <= '0;
      cycle_count     <= '0;
    end else if (start_ok) begin
      mode_q          <= mode_e'(mode);
      num_txn_q       <= num_txn;
      phase           <= '0;
      stall_cnt       <= '0;
      stalled         <= 1'b0;
      submitted_count <= '0;
      completed_count <= '0;
      cycle_count     <= '0;
    end else begin
      if (busy) begin
        cycle_count     <= sat_add(cycle_count, 32'd1);
        completed_count <= sat_add(completed_count, completions);
      end
      if (beat) begin
        submitted_count <= sat_add(submitted_count, 32'd1);
        phase           <= (phase == 32'(CONFLICT_PERIOD - 1)) ? '0 : phase + 32'd1;
      end
      // Stall window only counts consecutive completion-free DRAIN cycles.
      if (state == ST_DRAIN) begin
        stall_cnt <= (completions != '0) ? '0 : stall_cnt + 32'd1;
        if (!drained && stall_hit) stalled <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_svm_traffic_gen.sv
// Scoreboard bench for svm_traffic_gen: expected beats are queued at start and
// compared as the generator hands them over; run-level counters checked at done.
module tb_svm_traffic_gen;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int CP = 5;
  localparam int SL = 500;

  typedef struct {
    logic [63:0]   owner;
    logic [DW-1:0] rd;
    logic [DW-1:0] wr;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, start, m_axis_tready;
  logic [31:0]   num_txn, seed;
  logic [1:0]    mode;
  logic [N-1:0]  ready_mask, s_axis_tvalid, s_axis_tready;
  logic          m_axis_tvalid, busy, done, stalled;
  logic [63:0]   owner;
  logic [DW-1:0] rd_deps, wr_deps;
  logic [31:0]   submitted_count, completed_count, cycle_count;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    pending  = 0;
  bit    echo_en  = 1'b0;

  always #5 clk = ~clk;

  svm_traffic_gen #(
    .NUM_PARALLEL_INSTANCES (N),
    .MAX_DEPENDENCIES       (DW),
    .CONFLICT_PERIOD        (CP),
    .STALL_LIMIT            (SL)
  ) dut (
    .clk                             (clk),
    .rst                             (rst),
    .start                           (start),
    .num_txn                         (num_txn),
    .mode                            (mode),
    .seed                            (seed),
    .ready_mask                      (ready_mask),
    .m_axis_tvalid                   (m_axis_tvalid),
    .m_axis_tready                   (m_axis_tready),
    .m_axis_tdata_owner_programID    (owner),
    .m_axis_tdata_read_dependencies  (rd_deps),
    .m_axis_tdata_write_dependencies (wr_deps),
    .s_axis_tvalid                   (s_axis_tvalid),
    .s_axis_tready                   (s_axis_tready),
    .busy                            (busy),
    .done                            (done),
    .stalled                         (stalled),
    .submitted_count                 (submitted_count),
    .completed_count                 (completed_count),
    .cycle_count                     (cycle_count)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Reference payload for every transaction of a run, queued before start.
  task automatic push_expected(input int n, input logic [1:0] m, input logic [31:0] sd);
    logic [31:0]   s;
    logic [DW-1:0] one;
    beat_t         b;
    one = 1;
    s = (sd == 0) ? 32'h1 : sd;
    for (int i = 0; i < n; i++) begin
      b.owner = 64'(i);
      b.rd    = '0;
      b.wr    = '0;
      case (m)
        2'd0: if (i % CP == 0) b.wr = 'hff;
              else begin b.rd = 'hff00; b.wr = 'hff00_0000; end
        2'd1: b.wr = one << (i % DW);
        2'd2: begin
          b.rd = one << (int'(s[15:8]) % DW);
          b.wr = one << (int'(s[7:0]) % DW);
          s = lfsr_step(s);
        end
        default: b.wr = 'hff;
      endcase
      sb.push_back(b);
    end
  endtask

  // One clock: score any beat the coming edge will accept, then advance and echo completions.
  task automatic tick();
    bit    beat_now, comp_now;
    beat_t e;
    beat_now = !rst && m_axis_tvalid && m_axis_tready;
    comp_now = !rst && s_axis_tvalid[0] && s_axis_tready[0];
    if (beat_now) begin
      check("sb_has_entry", 256'(sb.size() > 0), 256'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("beat_owner", 256'(owner), 256'(e.owner));
        check("beat_read", rd_deps, e.rd);
        check("beat_write", wr_deps, e.wr);
      end
    end
    @(posedge clk);
    #1;
    if (rst) pending = 0;
    else if (echo_en) pending = pending + int'(beat_now) - int'(comp_now);
    if (echo_en) s_axis_tvalid = (pending > 0) ? 4'b0001 : 4'b0000;
  endtask

  task automatic start_run(input int n, input logic [1:0] m, input logic [31:0] sd, input bit echo);
    push_expected(n, m, sd);
    num_txn = 32'(n);
    mode    = m;
    seed    = sd;
    echo_en = echo;
    pending = 0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    check(tag, 256'(done), 256'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, 256'(m_axis_tvalid), 256'(0));
    check({tag, "_s_tready"}, 256'(s_axis_tready), 256'(0));
    check({tag, "_flags"}, 256'({busy, done, stalled}), 256'(0));
    check({tag, "_counts"}, 256'({submitted_count, completed_count, cycle_count}), 256'(0));
    check({tag, "_data"}, 256'(owner) | rd_deps | wr_deps, 256'(0));
  endtask

  logic [63:0]   snap_owner;
  logic [DW-1:0] snap_wr;

  initial begin
    rst = 1'b1; start = 1'b0; num_txn = '0; mode = '0; seed = '0;
    ready_mask = 4'hf; m_axis_tready = 1'b0; s_axis_tvalid = '0;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Periodic WAW with a sink that echoes each beat back on channel 0.
    m_axis_tready = 1'b1;
    start_run(10, 2'd0, 32'd0, 1'b1);
    check("m0_busy", 256'(busy), 256'(1));
    wait_done("m0_done", 200);
    check("m0_submitted", 256'(submitted_count), 256'(10));
    check("m0_completed", 256'(completed_count), 256'(10));
    check("m0_stalled", 256'(stalled), 256'(0));
    check("m0_cycles", 256'(cycle_count), 256'(12));
    tick(); tick(); tick();
    check("m0_frozen", 256'({done, submitted_count, completed_count, cycle_count}),
          256'({1'b1, 32'd10, 32'd10, 32'd12}));
    check("m0_sb_empty", 256'(sb.size()), 256'(0));

    // Disjoint mode with tready withheld for three cycles mid-run.
    start_run(6, 2'd1, 32'd0, 1'b1);
    tick(); tick();
    m_axis_tready = 1'b0;
    snap_owner = owner;
    snap_wr    = wr_deps;
    check("bp_owner_idx", 256'(snap_owner), 256'(2));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_tvalid", 256'(m_axis_tvalid), 256'(1));
      check("bp_owner_hold", 256'(owner), 256'(snap_owner));
      check("bp_write_hold", wr_deps, snap_wr);
      check("bp_submitted", 256'(submitted_count), 256'(2));
    end
    m_axis_tready = 1'b1;
    wait_done("bp_done", 100);
    check("bp_counts", 256'({submitted_count, completed_count}), 256'({32'd6, 32'd6}));

    // Several channels completing in one cycle, filtered by ready_mask.
    m_axis_tready = 1'b0;
    start_run(4, 2'd3, 32'd0, 1'b0);
    s_axis_tvalid = 4'hf;
    ready_mask    = 4'hf;
    tick();
    check("multi_all4", 256'(completed_count), 256'(4));
    ready_mask = 4'h5;
    #1;
    check("multi_s_tready", 256'(s_axis_tready), 256'(5));
    tick();
    check("multi_mask5", 256'(completed_count), 256'(6));
    s_axis_tvalid = '0;
    ready_mask    = 4'hf;
    m_axis_tready = 1'b1;
    wait_done("multi_done", 50);
    check("multi_final", 256'({submitted_count, completed_count, 31'd0, stalled}),
          256'({32'd4, 32'd6, 32'd0}));

    // No completions at all: abort on stall exactly STALL_LIMIT cycles into DRAIN.
    start_run(4, 2'd3, 32'd0, 1'b0);
    for (int i = 0; i < 20 && m_axis_tvalid; i++) tick();
    check("stall_in_drain", 256'({m_axis_tvalid, busy}), 256'({1'b0, 1'b1}));
    begin
      int n = 0;
      while (!done && n < SL + 20) begin
        tick();
        n++;
      end
      check("stall_latency", 256'(n), 256'(SL));
    end
    check("stall_flag", 256'({done, stalled}), 256'({1'b1, 1'b1}));
    check("stall_counts", 256'({submitted_count, completed_count}), 256'({32'd4, 32'd0}));

    // Reset mid-run after three beats, then replay from index 0.
    start_run(8, 2'd0, 32'd0, 1'b1);
    tick(); tick(); tick();
    check("rst_pre_submitted", 256'(submitted_count), 256'(3));
    rst = 1'b1;
    sb.delete();
    tick();
    check_idle_outputs("midrst");
    rst = 1'b0;
    s_axis_tvalid = '0;
    tick();
    start_run(8, 2'd0, 32'd0, 1'b1);
    check("replay_owner0", 256'(owner), 256'(0));
    wait_done("replay_done", 100);
    check("replay_counts", 256'({submitted_count, completed_count}), 256'({32'd8, 32'd8}));

    // LFSR mode from a zero seed twice (same sequence), then a nonzero seed.
    for (int r = 0; r < 2; r++) begin
      start_run(6, 2'd2, 32'd0, 1'b1);
      wait_done("lfsr_done", 100);
      check("lfsr_counts", 256'({submitted_count, completed_count}), 256'({32'd6, 32'd6}));
    end
    start_run(5, 2'd2, 32'h1234_abcd, 1'b1);
    wait_done("lfsr_seed_done", 100);
    check("lfsr_sb_empty", 256'(sb.size()), 256'(0));

    // Zero-length run goes straight to DRAIN and finishes the next cycle.
    start_run(0, 2'd2, 32'd0, 1'b1);
    check("zero_drain", 256'({m_axis_tvalid, busy, done}), 256'({1'b0, 1'b1, 1'b0}));
    tick();
    check("zero_done", 256'({done, stalled}), 256'({1'b1, 1'b0}));
    check("zero_counts", 256'({submitted_count, completed_count}), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
